// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed 8N1 serialiser with back-to-back frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits (8E1).
module uart_tx_fifo #(
  parameter int unsigned CLK_HZ     = 12000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned ClksPerBit = CLK_HZ / BAUD;
  localparam int unsigned CntW       = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam int unsigned PtrW       = $clog2(FIFO_DEPTH);
  localparam int unsigned CountW     = PtrW + 1;

  localparam logic [CntW-1:0]   CntLast   = CntW'(ClksPerBit - 1);
  localparam logic [CountW-1:0] CountFull = CountW'(FIFO_DEPTH);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] StParity = 3'd3;
`endif
  localparam logic [2:0] StStop   = 3'd4;

  // FIFO storage and bookkeeping
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CountW-1:0] count_q, count_d;
  logic              push, pop;
  logic [7:0]        head;

  // Serialiser state
  logic [2:0]        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [2:0]        next_idx;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              bit_end;

  assign wr_ready   = (count_q != CountFull);
  assign push       = wr_valid && wr_ready;
  assign head       = mem_q[rd_ptr_q];
  assign fifo_count = count_q;
  assign tx         = tx_q;
  assign busy       = (state_q != StIdle) || (count_q != '0);
  assign bit_end    = (cnt_q == CntLast);
  assign next_idx   = bit_idx_q + 3'd1;
  assign count_d    = count_q + CountW'(push) - CountW'(pop);

  // Storage is not reset; a flush only needs the pointers and count cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    pop       = 1'b0;

    case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = head;
          tx_d    = 1'b0;
          cnt_d   = '0;
          state_d = StStart;
        end
      end

      StStart: begin
        if (bit_end) begin
          tx_d      = shift_q[0];
          bit_idx_d = '0;
          cnt_d     = '0;
          state_d   = StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StData: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = ^shift_q;
            state_d = StParity;
`else
            tx_d    = 1'b1;
            state_d = StStop;
`endif
          end else begin
            bit_idx_d = next_idx;
            tx_d      = shift_q[next_idx];
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

`ifdef UART_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          cnt_d   = '0;
          tx_d    = 1'b1;
          state_d = StStop;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`endif

      StStop: begin
        if (bit_end) begin
          cnt_d = '0;
          // Chain straight into the next start bit so frames abut with no idle gap.
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = head;
            tx_d    = 1'b0;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      default: begin
        tx_d    = 1'b1;
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a time-based frame model checked every cycle plus directed
// literal checks. Honours UART_TX_PARITY_EN the same way as the design.
module tb_uart_tx_fifo;

  localparam int unsigned CLK_HZ = 12000000;
  localparam int unsigned BAUD   = 115200;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned CPB    = CLK_HZ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned NBITS     = 11;
  localparam int unsigned FRAME_LIT = 1144;
`else
  localparam int unsigned NBITS     = 10;
  localparam int unsigned FRAME_LIT = 1040;
`endif
  localparam int unsigned FRAME  = NBITS * CPB;
  localparam int unsigned BIT_T  = 104;
  localparam int unsigned HALF_T = 52;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] wr_data = 8'h00;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic       tx;
  logic       busy;
  logic [4:0] fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_fifo #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .tx        (tx),
    .busy      (busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired, got no event, required completion (t=%0t)",
             name, $time);
  endtask

  // Model: a frame started at cycle s drives bit floor((c-s)/CPB) of its serial image.
  int unsigned mcyc = 0;
  int unsigned mstart = 0;
  int unsigned pre;
  int unsigned k;
  logic [7:0]  mq[$];
  logic [7:0]  mbyte = 8'h00;
  bit          mact = 1'b0;
  bit          men = 1'b0;
  bit          macc;
  logic        exp_tx;

  always begin
    @(posedge clk);
    mcyc++;
    if (rst) begin
      mq.delete();
      mact = 1'b0;
      men  = 1'b1;
    end else begin
      pre  = mq.size();
      macc = wr_valid && (pre < DEPTH);
      if (mact && (mcyc - mstart) == FRAME) mact = 1'b0;
      if (!mact && pre != 0) begin
        mbyte  = mq.pop_front();
        mact   = 1'b1;
        mstart = mcyc;
      end
      if (macc) mq.push_back(wr_data);
    end
    @(negedge clk);
    if (men) begin
      if (!mact) begin
        exp_tx = 1'b1;
      end else begin
        k = (mcyc - mstart) / CPB;
        if (k == 0) exp_tx = 1'b0;
        else if (k <= 8) exp_tx = mbyte[k-1];
`ifdef UART_TX_PARITY_EN
        else if (k == 9) exp_tx = ^mbyte;
`endif
        else exp_tx = 1'b1;
      end
      chk("model_tx", 32'(tx), 32'(exp_tx));
      chk("model_busy", 32'(busy), 32'(mact || mq.size() != 0));
      chk("model_wr_ready", 32'(wr_ready), 32'(mq.size() < DEPTH));
      chk("model_fifo_count", 32'(fifo_count), 32'(mq.size()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic advance(input int n);
    repeat (n) tick();
  endtask

  task automatic write_byte(input logic [7:0] b);
    int  n = 0;
    logic acc;
    wr_data  = b;
    wr_valid = 1'b1;
    forever begin
      acc = wr_ready;
      tick();
      if (acc === 1'b1) break;
      n++;
      if (n > 2 * FRAME_LIT) begin
        timeout_fail("write_accept");
        break;
      end
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy !== 1'b0) begin
      if (n >= 20 * FRAME_LIT) begin
        timeout_fail(name);
        break;
      end
      tick();
      n++;
    end
  endtask

  // Call just after the start-bit edge; returns just after the edge that ends the stop bit.
  task automatic rx_frame(output logic [7:0] b, output logic st, output logic par,
                          output logic sp);
    advance(HALF_T);
    st = tx;
    for (int i = 0; i < 8; i++) begin
      advance(BIT_T);
      b[i] = tx;
    end
`ifdef UART_TX_PARITY_EN
    advance(BIT_T);
    par = tx;
`else
    par = 1'b0;
`endif
    advance(BIT_T);
    sp = tx;
    advance(HALF_T);
  endtask

  logic [7:0]  rb;
  logic        st, par, sp;
  logic [10:0] lvl;

  initial begin
    // 1: reset held five cycles
    rst = 1'b1;
    repeat (5) begin
      tick();
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wr_ready", 32'(wr_ready), 32'd1);
      chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    end
    rst = 1'b0;
    tick();

    // 2: single byte 0x55, bit levels and busy duration
`ifdef UART_TX_PARITY_EN
    lvl = 11'b10010101010;
`else
    lvl = 11'b01010101010;
`endif
    write_byte(8'h55);
    chk("t2_count_after_write", 32'(fifo_count), 32'd1);
    chk("t2_tx_before_pop", 32'(tx), 32'd1);
    tick();
    chk("t2_tx_fall", 32'(tx), 32'd0);
    for (int i = 0; i < NBITS; i++) begin
      advance(HALF_T);
      chk($sformatf("t2_level%0d", i), 32'(tx), 32'(lvl[i]));
      advance(HALF_T - 1);
      chk($sformatf("t2_busy%0d", i), 32'(busy), 32'd1);
      advance(1);
    end
    chk("t2_busy_end", 32'(busy), 32'd0);

    // 3: two bytes back to back
    write_byte(8'hA3);
    write_byte(8'h0F);
    rx_frame(rb, st, par, sp);
    chk("t3_byte0", 32'(rb), 32'hA3);
    chk("t3_start0", 32'(st), 32'd0);
    chk("t3_stop0", 32'(sp), 32'd1);
    chk("t3_second_start", 32'(tx), 32'd0);
    rx_frame(rb, st, par, sp);
    chk("t3_byte1", 32'(rb), 32'h0F);
    chk("t3_stop1", 32'(sp), 32'd1);
    chk("t3_busy_end", 32'(busy), 32'd0);

    // 4: 17 writes fill a 16-deep FIFO behind the byte in flight
    for (int i = 0; i < 17; i++) write_byte(8'h10 + 8'(i));
    chk("t4_full_count", 32'(fifo_count), 32'd16);
    chk("t4_full_ready", 32'(wr_ready), 32'd0);
    wr_data  = 8'hEE;
    wr_valid = 1'b1;
    begin
      int n = 0;
      while (wr_ready !== 1'b1) begin
        if (n >= 2 * FRAME_LIT) begin
          timeout_fail("t4_ready_rise");
          break;
        end
        tick();
        n++;
      end
    end
    chk("t4_count_at_ready", 32'(fifo_count), 32'd15);
    tick();
    wr_valid = 1'b0;
    chk("t4_count_refill", 32'(fifo_count), 32'd16);
    wait_idle("t4_drain");

    // 5: reset during data bit 3 of 0xFF with four bytes queued
    write_byte(8'hFF);
    for (int i = 1; i <= 4; i++) write_byte(8'(i));
    chk("t5_queued", 32'(fifo_count), 32'd4);
    advance(457);
    chk("t5_bit3_level", 32'(tx), 32'd1);
    chk("t5_busy_mid", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_tx", 32'(tx), 32'd1);
    chk("t5_rst_count", 32'(fifo_count), 32'd0);
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_ready", 32'(wr_ready), 32'd1);
    advance(3);
    write_byte(8'h3C);
    tick();
    chk("t5_fall", 32'(tx), 32'd0);
    rx_frame(rb, st, par, sp);
    chk("t5_byte", 32'(rb), 32'h3C);
    chk("t5_stop", 32'(sp), 32'd1);
    chk("t5_busy_end", 32'(busy), 32'd0);

`ifdef UART_TX_PARITY_EN
    // 6: even parity bit
    write_byte(8'h07);
    tick();
    rx_frame(rb, st, par, sp);
    chk("t6_byte07", 32'(rb), 32'h07);
    chk("t6_parity07", 32'(par), 32'd1);
    chk("t6_busy07_end", 32'(busy), 32'd0);
    write_byte(8'h03);
    tick();
    rx_frame(rb, st, par, sp);
    chk("t6_byte03", 32'(rb), 32'h03);
    chk("t6_parity03", 32'(par), 32'd0);
    chk("t6_busy03_end", 32'(busy), 32'd0);
`endif

    advance(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
